// File: rtl/opfetch_pkg.sv
// Shared types and constants for the operand fetch stage: widths, FSM states,
// B-path shift encodings and the captured issue request.
package opfetch_pkg;
    localparam int DATA_W = 16;
    localparam int NREG   = 8;
    localparam int AW     = $clog2(NREG);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_A = 2'd1,
        READ_B = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    typedef struct packed {
        logic [AW-1:0]     rn;
        logic [AW-1:0]     rm;
        logic [1:0]        shift;
        logic              asel;
        logic              bsel;
        logic [DATA_W-1:0] sximm5;
        logic [1:0]        alu_op;
    } req_t;

    // Single-bit shifts; the bit shifted out is dropped.
    function automatic logic [DATA_W-1:0] shift_b(input logic [DATA_W-1:0] b,
                                                  input logic [1:0] sh);
        case (sh)
            SH_LSL:  shift_b = {b[DATA_W-2:0], 1'b0};
            SH_LSR:  shift_b = {1'b0, b[DATA_W-1:1]};
            SH_ASR:  shift_b = {b[DATA_W-1], b[DATA_W-1:1]};
            default: shift_b = b;
        endcase
    endfunction
endpackage

// File: rtl/regfile.sv
// General-purpose register file: one write port, one combinational read port.
// Optional write-through on the read port under OPFETCH_BYPASS_EN.
module regfile
    import opfetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [NREG-1:0][DATA_W-1:0] mem;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            mem <= '0;
        else if (we)
            mem[waddr] <= wdata;
    end

`ifdef OPFETCH_BYPASS_EN
    assign rdata = (we && (waddr == raddr)) ? wdata : mem[raddr];
`else
    assign rdata = mem[raddr];
`endif
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads Rn then Rm over two cycles through one read port,
// applies B shifter and source muxes, and holds Ain/Bin/alu_op under valid/ready.
// Build option: OPFETCH_BYPASS_EN enables register-file write-through on reads.
module operand_fetch
    import opfetch_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [AW-1:0]     rn,
    input  logic [AW-1:0]     rm,
    input  logic [1:0]        shift,
    input  logic              asel,
    input  logic              bsel,
    input  logic [DATA_W-1:0] sximm5,
    input  logic [1:0]        alu_op_in,
    input  logic              wb_en,
    input  logic [AW-1:0]     wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    output logic [DATA_W-1:0] Ain,
    output logic [DATA_W-1:0] Bin,
    output logic [1:0]        alu_op,
    output logic              out_valid,
    input  logic              out_ready
);
    state_t            state;
    req_t              req_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] rdata;

    regfile u_rf (
        .clk   (clk),
        .reset (reset),
        .we    (wb_en),
        .waddr (wb_reg),
        .wdata (wb_data),
        .raddr (raddr),
        .rdata (rdata)
    );

    assign raddr = (state == READ_B) ? req_q.rm : req_q.rn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            req_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            case (state)
                IDLE: if (issue_valid) begin
                    req_q <= '{rn: rn, rm: rm, shift: shift, asel: asel, bsel: bsel,
                               sximm5: sximm5, alu_op: alu_op_in};
                    state <= READ_A;
                end
                // A is read even when asel masks it, keeping the cadence fixed.
                READ_A: begin
                    a_q   <= rdata;
                    state <= READ_B;
                end
                READ_B: begin
                    b_q   <= rdata;
                    state <= HOLD;
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs derive only from latched state, so they stay stable through HOLD.
    assign issue_ready = (state == IDLE);
    assign out_valid   = (state == HOLD);
    assign alu_op      = req_q.alu_op;
    assign Ain         = req_q.asel ? '0 : a_q;
    assign Bin         = req_q.bsel ? req_q.sximm5 : shift_b(b_q, req_q.shift);
endmodule

// File: tb/tb_operand_fetch.sv
// Directed self-checking bench for operand_fetch.
module tb_operand_fetch;
    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, issue_ready;
    logic [2:0]  rn, rm;
    logic [1:0]  shift;
    logic        asel, bsel;
    logic [15:0] sximm5;
    logic [1:0]  alu_op_in, alu_op;
    logic        wb_en;
    logic [2:0]  wb_reg;
    logic [15:0] wb_data;
    logic [15:0] Ain, Bin;
    logic        out_valid, out_ready;

    int total = 0;
    int bad   = 0;

`ifdef OPFETCH_BYPASS_EN
    localparam logic [15:0] BYP_EXP = 16'h1234;
`else
    localparam logic [15:0] BYP_EXP = 16'h0011;
`endif

    operand_fetch dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rn(rn), .rm(rm), .shift(shift), .asel(asel), .bsel(bsel), .sximm5(sximm5),
        .alu_op_in(alu_op_in), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .Ain(Ain), .Bin(Bin), .alu_op(alu_op), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [2:0] r, input logic [15:0] d);
        wb_en = 1'b1; wb_reg = r; wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    task automatic set_req(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                           input logic as, input logic bs, input logic [15:0] imm,
                           input logic [1:0] op);
        rn = a; rm = b; shift = sh; asel = as; bsel = bs; sximm5 = imm; alu_op_in = op;
    endtask

    // Issue one request and wait (bounded) until the stage reaches HOLD.
    task automatic issue_to_hold(input logic [2:0] a, input logic [2:0] b, input logic [1:0] sh,
                                 input logic as, input logic bs, input logic [15:0] imm,
                                 input logic [1:0] op);
        int n;
        set_req(a, b, sh, as, bs, imm, op);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL hold_timeout: out_valid=%b after %0d cycles, required 1", out_valid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        total++;
        if (issue_ready !== 1'b1 || out_valid !== 1'b0 || Ain !== 16'h0 || Bin !== 16'h0 || alu_op !== 2'b00) begin
            bad++;
            $display("FAIL reset_outputs: ir=%b ov=%b Ain=%h Bin=%h op=%b, required 1 0 0000 0000 00",
                     issue_ready, out_valid, Ain, Bin, alu_op);
        end
        issue_valid = 1'b1;
        step(); step();
        issue_valid = 1'b0;
        reset = 1'b0;
        step();
        total++;
        if (issue_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ignores_issue: ir=%b ov=%b, required 1 0", issue_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        wr_reg(3'd0, 16'h0007);
        wr_reg(3'd1, 16'h0002);
        set_req(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        total++;
        if (out_valid !== 1'b0 || issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_cycle1: ov=%b ir=%b, required 0 0", out_valid, issue_ready);
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL basic_cycle2: ov=%b, required 0", out_valid);
        end
        step();
        total++;
        if (out_valid !== 1'b1 || Ain !== 16'h0007 || Bin !== 16'h0002 || alu_op !== 2'b01) begin
            bad++;
            $display("FAIL basic_cycle3: ov=%b Ain=%h Bin=%h op=%b, required 1 0007 0002 01",
                     out_valid, Ain, Bin, alu_op);
        end
        step();
        total++;
        if (out_valid !== 1'b0 || issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release: ov=%b ir=%b, required 0 1", out_valid, issue_ready);
        end
    endtask

    task automatic test_shifter();
        logic [15:0] exp_b [4];
        exp_b = '{16'h8001, 16'h0002, 16'h4000, 16'hC000};
        wr_reg(3'd1, 16'h8001);
        for (int s = 0; s < 4; s++) begin
            issue_to_hold(3'd0, 3'd1, 2'(s), 1'b0, 1'b0, 16'h0, 2'b10);
            total++;
            if (Bin !== exp_b[s] || alu_op !== 2'b10) begin
                bad++;
                $display("FAIL shift_%0d: Bin=%h op=%b, required %h 10", s, Bin, alu_op, exp_b[s]);
            end
            step();
        end
    endtask

    task automatic test_muxes();
        wr_reg(3'd0, 16'h1234);
        issue_to_hold(3'd0, 3'd1, 2'b01, 1'b1, 1'b1, 16'hFFF0, 2'b11);
        total++;
        if (Ain !== 16'h0000 || Bin !== 16'hFFF0 || alu_op !== 2'b11) begin
            bad++;
            $display("FAIL src_mux: Ain=%h Bin=%h op=%b, required 0000 FFF0 11", Ain, Bin, alu_op);
        end
        step();
    endtask

    // issue_valid held high: a new handshake every 4 cycles.
    task automatic test_back_to_back();
        int holds, idles;
        wr_reg(3'd2, 16'h0003);
        wr_reg(3'd3, 16'h0004);
        set_req(3'd2, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        holds = 0; idles = 0;
        issue_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) begin
                holds++;
                total++;
                if (Ain !== 16'h0003 || Bin !== 16'h0004) begin
                    bad++;
                    $display("FAIL b2b_data: Ain=%h Bin=%h, required 0003 0004", Ain, Bin);
                end
            end
            if (issue_ready) idles++;
        end
        issue_valid = 1'b0;
        total++;
        if (holds != 2 || idles != 2) begin
            bad++;
            $display("FAIL b2b_rate: holds=%0d idles=%0d in 8 cycles, required 2 2", holds, idles);
        end
        step();
    endtask

    task automatic test_backpressure();
        wr_reg(3'd0, 16'h00AA);
        wr_reg(3'd1, 16'h0055);
        out_ready = 1'b0;
        issue_to_hold(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b01);
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || issue_ready !== 1'b0 || Ain !== 16'h00AA ||
                Bin !== 16'h0055 || alu_op !== 2'b01) begin
                bad++;
                $display("FAIL hold_stable_%0d: ov=%b ir=%b Ain=%h Bin=%h op=%b, required 1 0 00AA 0055 01",
                         i, out_valid, issue_ready, Ain, Bin, alu_op);
            end
            if (i == 1) begin
                wb_en = 1'b1; wb_reg = 3'd0; wb_data = 16'hBEEF;
                set_req(3'd1, 3'd1, 2'b11, 1'b1, 1'b1, 16'h1111, 2'b11);
                issue_valid = 1'b1;
            end
            step();
            wb_en = 1'b0;
            issue_valid = 1'b0;
        end
        out_ready = 1'b1;
        step();
        total++;
        if (out_valid !== 1'b0 || issue_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release: ov=%b ir=%b, required 0 1", out_valid, issue_ready);
        end
        issue_to_hold(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        total++;
        if (Ain !== 16'hBEEF) begin
            bad++;
            $display("FAIL hold_write_landed: Ain=%h, required BEEF", Ain);
        end
        step();
    endtask

    task automatic test_issue_write();
        set_req(3'd3, 3'd3, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        issue_valid = 1'b1;
        wb_en = 1'b1; wb_reg = 3'd3; wb_data = 16'h7777;
        step();
        issue_valid = 1'b0;
        wb_en = 1'b0;
        step(); step();
        total++;
        if (out_valid !== 1'b1 || Ain !== 16'h7777) begin
            bad++;
            $display("FAIL issue_cycle_write: ov=%b Ain=%h, required 1 7777", out_valid, Ain);
        end
        step();
    endtask

    task automatic test_bypass();
        wr_reg(3'd0, 16'h0011);
        set_req(3'd0, 3'd1, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        wb_en = 1'b1; wb_reg = 3'd0; wb_data = 16'h1234;
        step();
        wb_en = 1'b0;
        step();
        total++;
        if (out_valid !== 1'b1 || Ain !== BYP_EXP) begin
            bad++;
            $display("FAIL bypass_read: ov=%b Ain=%h, required 1 %h", out_valid, Ain, BYP_EXP);
        end
        step();
        issue_to_hold(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        total++;
        if (Ain !== 16'h1234) begin
            bad++;
            $display("FAIL bypass_after: Ain=%h, required 1234", Ain);
        end
        step();
    endtask

    task automatic test_reset_mid();
        wr_reg(3'd2, 16'h5555);
        wr_reg(3'd5, 16'hA5A5);
        set_req(3'd2, 3'd5, 2'b01, 1'b0, 1'b0, 16'h0, 2'b11);
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        total++;
        if (issue_ready !== 1'b1 || out_valid !== 1'b0 || Ain !== 16'h0 || Bin !== 16'h0 || alu_op !== 2'b00) begin
            bad++;
            $display("FAIL reset_mid: ir=%b ov=%b Ain=%h Bin=%h op=%b, required 1 0 0000 0000 00",
                     issue_ready, out_valid, Ain, Bin, alu_op);
        end
        step();
        reset = 1'b0;
        step();
        for (int r = 0; r < 8; r++) begin
            issue_to_hold(3'(r), 3'(r), 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
            total++;
            if (Ain !== 16'h0 || Bin !== 16'h0) begin
                bad++;
                $display("FAIL rf_cleared_r%0d: Ain=%h Bin=%h, required 0000 0000", r, Ain, Bin);
            end
            step();
        end
    endtask

    initial begin
        issue_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0; wb_reg = '0; wb_data = '0;
        set_req(3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 16'h0, 2'b00);
        test_reset();
        test_basic();
        test_shifter();
        test_muxes();
        test_back_to_back();
        test_backpressure();
        test_issue_write();
        test_bypass();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
